// File: rtl/timer_counter0.sv
// 8051-style Timer 0: modes 0-3 with gating, auto-reload and split-timer TH0.
// Optional T0 external-count support is built in when TIMER0_COUNTER_EN is defined.
module timer_counter0 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic [7:0] i_tmod,
  input  logic       i_tr0,
  input  logic       i_tr1,
  input  logic       i_int0,
  input  logic       i_t0,
  input  logic [7:0] i_byte,
  input  logic       i_wr_tl0,
  input  logic       i_wr_th0,
  input  logic       i_tf0_clr,
  output logic [7:0] o_tl0,
  output logic [7:0] o_th0,
  output logic       o_tf0,
  output logic       o_tf1_set
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LOW_W  = 5;

  localparam logic [1:0] MODE_13BIT  = 2'b00;
  localparam logic [1:0] MODE_16BIT  = 2'b01;
  localparam logic [1:0] MODE_RELOAD = 2'b10;
  localparam logic [1:0] MODE_SPLIT  = 2'b11;

  logic              cnt_src_c;
  logic              run0_c;
  logic              ev0_c;
  logic              ev1_c;
  logic              ovf0_c;
  logic              ovf1_c;
  logic [BYTE_W-1:0] tl_nxt_c;
  logic [BYTE_W-1:0] th_nxt_c;
  logic              unused_bits;

`ifdef TIMER0_COUNTER_EN
  logic t0_meta;
  logic t0_sync;
  logic t0_samp;

  // Two-flop synchroniser, then sample once per machine cycle for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t0_meta <= 1'b0;
      t0_sync <= 1'b0;
      t0_samp <= 1'b0;
    end else begin
      t0_meta <= i_t0;
      t0_sync <= t0_meta;
      if (i_tick) t0_samp <= t0_sync;
    end
  end

  assign cnt_src_c   = i_tmod[2] ? (i_tick & t0_samp & ~t0_sync) : i_tick;
  assign unused_bits = &{1'b0, i_tmod[7:4]};
`else
  assign cnt_src_c   = i_tick;
  assign unused_bits = &{1'b0, i_tmod[7:4], i_tmod[2], i_t0};
`endif

  assign run0_c = i_tr0 & (~i_tmod[3] | i_int0);
  assign ev0_c  = run0_c & cnt_src_c;
  assign ev1_c  = i_tick & i_tr1;

  // Next counter state; a CPU write to a byte overrides its count and blocks carries out of it.
  always_comb begin
    tl_nxt_c = o_tl0;
    th_nxt_c = o_th0;
    ovf0_c   = 1'b0;
    ovf1_c   = 1'b0;
    case (i_tmod[1:0])
      MODE_13BIT: begin
        if (ev0_c) begin
          tl_nxt_c = {o_tl0[BYTE_W-1:LOW_W], o_tl0[LOW_W-1:0] + LOW_W'(1)};
          if ((&o_tl0[LOW_W-1:0]) && !i_wr_tl0) th_nxt_c = o_th0 + BYTE_W'(1);
          ovf0_c = (&o_tl0[LOW_W-1:0]) & (&o_th0) & ~i_wr_tl0 & ~i_wr_th0;
        end
      end
      MODE_16BIT: begin
        if (ev0_c) begin
          tl_nxt_c = o_tl0 + BYTE_W'(1);
          if ((&o_tl0) && !i_wr_tl0) th_nxt_c = o_th0 + BYTE_W'(1);
          ovf0_c = (&o_tl0) & (&o_th0) & ~i_wr_tl0 & ~i_wr_th0;
        end
      end
      MODE_RELOAD: begin
        if (ev0_c) begin
          tl_nxt_c = (&o_tl0) ? o_th0 : o_tl0 + BYTE_W'(1);
          ovf0_c   = (&o_tl0) & ~i_wr_tl0;
        end
      end
      MODE_SPLIT: begin
        if (ev0_c) begin
          tl_nxt_c = o_tl0 + BYTE_W'(1);
          ovf0_c   = (&o_tl0) & ~i_wr_tl0;
        end
        if (ev1_c) begin
          th_nxt_c = o_th0 + BYTE_W'(1);
          ovf1_c   = (&o_th0) & ~i_wr_th0;
        end
      end
      default: begin
        tl_nxt_c = o_tl0;
        th_nxt_c = o_th0;
      end
    endcase
    if (i_wr_tl0) tl_nxt_c = i_byte;
    if (i_wr_th0) th_nxt_c = i_byte;
  end

  // Counter and flag registers; overflow set beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tl0     <= '0;
      o_th0     <= '0;
      o_tf0     <= 1'b0;
      o_tf1_set <= 1'b0;
    end else begin
      o_tl0     <= tl_nxt_c;
      o_th0     <= th_nxt_c;
      o_tf0     <= ovf0_c | (o_tf0 & ~i_tf0_clr);
      o_tf1_set <= ovf1_c;
    end
  end

endmodule

// File: doc/timer_counter0.md
TIMER_COUNTER0 -- requirements
Module: timer_counter0

Interface
REQ-001 SHALL have no parameters; all behaviour is set by ports and the TIMER0_COUNTER_EN macro.
REQ-002 SHALL provide: i_clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL provide: i_rst  in  1  synchronous, active-high reset, sampled on i_clk rising edge.
REQ-004 SHALL provide: i_tick  in  1  machine-cycle enable, one-cycle pulse, one per 12 i_clk.
REQ-005 SHALL provide: i_tmod  in  8  TMOD register value; bits [3:0] used: [3]=GATE, [2]=C/T, [1:0]=M1M0.
REQ-006 SHALL provide: i_tr0  in  1  TCON.TR0 run control; i_tr1  in  1  TCON.TR1 (mode 3 TH0 run).
REQ-007 SHALL provide: i_int0  in  1  INT0 pin level, high = gate open; i_t0  in  1  T0 external count pin, asynchronous.
REQ-008 SHALL provide: i_byte  in  8  write data; i_wr_tl0  in  1  load TL0; i_wr_th0  in  1  load TH0.
REQ-009 SHALL provide: i_tf0_clr  in  1  clear TF0 (software write or interrupt vectoring).
REQ-010 SHALL provide: o_tl0  out  8; o_th0  out  8; o_tf0  out  1 overflow flag; o_tf1_set  out  1 one-cycle pulse, mode 3 TH0 overflow.

Function
REQ-011 SHALL compute run0 = i_tr0 AND (NOT GATE OR i_int0); count event ev0 = run0 AND (timer: i_tick; counter: detected T0 falling edge).
REQ-012 Mode 0 (00): SHALL count 13 bits {TH0, TL0[4:0]}; TL0[7:5] held; overflow when value 0x1FFF increments to 0.
REQ-013 Mode 1 (01): SHALL count 16 bits {TH0, TL0}; overflow on 0xFFFF -> 0x0000.
REQ-014 Mode 2 (10): SHALL count TL0 only; on TL0 0xFF + ev0, TL0 <= TH0 (auto-reload) and overflow; TH0 unchanged.
REQ-015 Mode 3 (11): TL0 SHALL be 8-bit counter on ev0 (GATE, C/T honoured), overflow -> TF0; TH0 SHALL be 8-bit timer on i_tick AND i_tr1 only, overflow 0xFF->0x00 pulses o_tf1_set one cycle.
REQ-016 SHALL set o_tf0 in the cycle after overflow; it SHALL remain set until i_tf0_clr.
REQ-017 Simultaneous overflow and i_tf0_clr: set SHALL win.
REQ-018 CPU write and increment to the same byte in one cycle: write SHALL win for that byte; the carry into the other byte is discarded.
REQ-019 Mode change mid-count SHALL take effect on the next ev0; TL0/TH0 contents SHALL be preserved.
REQ-020 Counting SHALL occur at most once per i_clk; latency from event to updated o_tl0/o_th0 SHALL be one clock.

Reset
REQ-021 On i_rst=1: TL0=0x00, TH0=0x00, o_tf0=0, o_tf1_set=0, T0 synchroniser and edge history cleared.
REQ-022 Reset SHALL override writes, ticks and clears in the same cycle; a count in progress is lost.

Configuration
REQ-023 Macro TIMER0_COUNTER_EN defined: C/T=1 SHALL count T0 falling edges (2-flop synchroniser; T0 sampled on i_tick; edge = previous sample 1, current sample 0; max rate 1 per 2 ticks).
REQ-024 Macro TIMER0_COUNTER_EN undefined: C/T SHALL be ignored, always timer mode; i_t0 unused and synchroniser omitted.

Verification
REQ-025 Mode 1, TH0/TL0=0xFF/0xFE, TR0=1, two ticks -> 0x00/0x00, o_tf0=1; i_tf0_clr -> o_tf0=0 next cycle.
REQ-026 Mode 2, TH0=0x9C, TL0=0xFF, one tick -> TL0=0x9C, TH0=0x9C, o_tf0=1.
REQ-027 Mode 0, TH0=0xFF, TL0=0xFF, one tick -> TH0=0x00, TL0=0xE0, o_tf0=1.
REQ-028 GATE=1, TR0=1, i_int0=0, 50 ticks -> TL0 unchanged; i_int0=1, 3 ticks -> TL0 +3.
REQ-029 Mode 3, TR1=1, TR0=0, TH0=0xFF, one tick -> TH0=0x00, o_tf1_set pulse 1 cycle, o_tf0=0, TL0 unchanged.
REQ-030 TIMER0_COUNTER_EN, C/T=1, mode 1, 5 T0 low pulses each spanning 2 ticks -> TL0=0x05; i_wr_tl0=1 with tick-coincident edge, i_byte=0x40 -> TL0=0x40.
